// File: rtl/pe_row_mac.sv
// Row-stationary PE: holds one filter row, slides a stride-1 window over an ifmap row
// and adds each dot product to the neighbour psum. Define PE_PSUM_SAT_EN to saturate psum_o.
module pe_row_mac #(
    parameter int DATA_W     = 8,
    parameter int PSUM_W     = 10,
    parameter int MAX_FILT_W = 3,
    parameter int MAX_OUT    = 16,
    parameter int LEN_W      = $clog2(MAX_FILT_W + 1),
    parameter int OUT_W      = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic [OUT_W-1:0]  cfg_num_out_i,
    input  logic [DATA_W-1:0] filter_i,
    input  logic              filter_valid_i,
    output logic              filter_ready_o,
    input  logic [DATA_W-1:0] ifmap_i,
    input  logic              ifmap_valid_i,
    output logic              ifmap_ready_o,
    input  logic [PSUM_W-1:0] psum_i,
    input  logic              psum_valid_i,
    output logic              psum_ready_o,
    output logic [PSUM_W-1:0] psum_o,
    output logic              psum_valid_o,
    input  logic              psum_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o
);

    localparam int ACC_W = 2 * DATA_W + $clog2(MAX_FILT_W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_F,
        FILL,
        MAC,
        PSUM,
        OUT,
        SHIFT
    } state_t;

    state_t state, next_state;

    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         cnt;
    logic [OUT_W-1:0]         num_out_q;
    logic [OUT_W-1:0]         outputs_done;
    logic [OUT_W-1:0]         done_next;
    logic signed [DATA_W-1:0] f [MAX_FILT_W];
    logic signed [DATA_W-1:0] x [MAX_FILT_W];
    logic signed [ACC_W-1:0]  acc;
    logic signed [2*DATA_W-1:0] prod;
    logic [PSUM_W-1:0]        fit_val;
    logic                     cfg_ok;
    logic                     cnt_last;
    logic                     row_last;
    logic                     window_shift;

    // Widen by one bit so the upper-bound compares stay meaningful when the port width is exact.
    assign cfg_ok = (cfg_len_i != '0)
                 && ({1'b0, cfg_len_i} <= (LEN_W + 1)'(MAX_FILT_W))
                 && (cfg_num_out_i != '0)
                 && ({1'b0, cfg_num_out_i} <= (OUT_W + 1)'(MAX_OUT));

    assign cnt_last     = (cnt == len_q - LEN_W'(1));
    assign done_next    = outputs_done + OUT_W'(1);
    assign row_last     = (done_next == num_out_q);
    assign prod         = f[cnt] * x[cnt];
    assign window_shift = ((state == FILL) || (state == SHIFT)) && ifmap_valid_i;

    assign filter_ready_o = (state == LOAD_F);
    assign ifmap_ready_o  = (state == FILL) || (state == SHIFT);
    assign psum_ready_o   = (state == PSUM);
    assign busy_o         = (state != IDLE);

`ifdef PE_PSUM_SAT_EN
    localparam int SUM_W = ((ACC_W > PSUM_W) ? ACC_W : PSUM_W) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (PSUM_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [SUM_W-1:0] sum;

    assign sum = SUM_W'(acc) + SUM_W'($signed(psum_i));

    always_comb begin
        fit_val = sum[PSUM_W-1:0];
        if (sum > SAT_MAX) begin
            fit_val = SAT_MAX[PSUM_W-1:0];
        end else if (sum < SAT_MIN) begin
            fit_val = SAT_MIN[PSUM_W-1:0];
        end
    end
`else
    always_comb begin
        fit_val = PSUM_W'(acc) + psum_i;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (cfg_start_i && cfg_ok) next_state = LOAD_F;
            LOAD_F: if (filter_valid_i && cnt_last) next_state = FILL;
            FILL:   if (ifmap_valid_i && cnt_last) next_state = MAC;
            MAC:    if (cnt_last) next_state = PSUM;
            PSUM:   if (psum_valid_i) next_state = OUT;
            OUT:    if (psum_ready_i) next_state = row_last ? IDLE : SHIFT;
            SHIFT:  if (ifmap_valid_i) next_state = MAC;
            default: next_state = IDLE;
        endcase
    end

    // Counters, accumulator and the registered output side; the single cnt is reused by LOAD_F, FILL and MAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q        <= '0;
            num_out_q    <= '0;
            cnt          <= '0;
            outputs_done <= '0;
            acc          <= '0;
            psum_o       <= '0;
            psum_valid_o <= 1'b0;
            done_o       <= 1'b0;
            cfg_err_o    <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            cfg_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start_i) begin
                        if (cfg_ok) begin
                            len_q        <= cfg_len_i;
                            num_out_q    <= cfg_num_out_i;
                            cnt          <= '0;
                            outputs_done <= '0;
                        end else begin
                            cfg_err_o <= 1'b1;
                        end
                    end
                end
                LOAD_F: begin
                    if (filter_valid_i) begin
                        cnt <= cnt_last ? '0 : cnt + LEN_W'(1);
                    end
                end
                FILL: begin
                    if (ifmap_valid_i) begin
                        cnt <= cnt_last ? '0 : cnt + LEN_W'(1);
                        if (cnt_last) begin
                            acc <= '0;
                        end
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    cnt <= cnt_last ? '0 : cnt + LEN_W'(1);
                end
                PSUM: begin
                    if (psum_valid_i) begin
                        psum_o       <= fit_val;
                        psum_valid_o <= 1'b1;
                    end
                end
                OUT: begin
                    if (psum_ready_i) begin
                        psum_valid_o <= 1'b0;
                        outputs_done <= done_next;
                        if (row_last) begin
                            done_o <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (ifmap_valid_i) begin
                        acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scratchpad and window hold no reset: their contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if ((state == LOAD_F) && filter_valid_i) begin
            f[cnt] <= $signed(filter_i);
        end
        if (window_shift) begin
            for (int i = 0; i < MAX_FILT_W - 1; i++) begin
                if (i < int'(len_q) - 1) begin
                    x[i] <= x[i + 1];
                end
            end
            x[len_q - LEN_W'(1)] <= $signed(ifmap_i);
        end
    end

endmodule

// File: tb/tb_pe_row_mac.sv
// Directed self-checking bench for pe_row_mac: dot products, psum add/stall, overflow,
// backpressure, config errors and mid-row reset.
module tb_pe_row_mac;

    localparam int DATA_W = 8;
    localparam int PSUM_W = 10;
    localparam int LEN_W  = 2;
    localparam int OUT_W  = 5;

    logic              clk;
    logic              rst;
    logic              cfg_start_i;
    logic [LEN_W-1:0]  cfg_len_i;
    logic [OUT_W-1:0]  cfg_num_out_i;
    logic [DATA_W-1:0] filter_i;
    logic              filter_valid_i;
    logic              filter_ready_o;
    logic [DATA_W-1:0] ifmap_i;
    logic              ifmap_valid_i;
    logic              ifmap_ready_o;
    logic [PSUM_W-1:0] psum_i;
    logic              psum_valid_i;
    logic              psum_ready_o;
    logic [PSUM_W-1:0] psum_o;
    logic              psum_valid_o;
    logic              psum_ready_i;
    logic              busy_o;
    logic              done_o;
    logic              cfg_err_o;

    int compared   = 0;
    int mismatched = 0;

    pe_row_mac dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start_i    (cfg_start_i),
        .cfg_len_i      (cfg_len_i),
        .cfg_num_out_i  (cfg_num_out_i),
        .filter_i       (filter_i),
        .filter_valid_i (filter_valid_i),
        .filter_ready_o (filter_ready_o),
        .ifmap_i        (ifmap_i),
        .ifmap_valid_i  (ifmap_valid_i),
        .ifmap_ready_o  (ifmap_ready_o),
        .psum_i         (psum_i),
        .psum_valid_i   (psum_valid_i),
        .psum_ready_o   (psum_ready_o),
        .psum_o         (psum_o),
        .psum_valid_o   (psum_valid_o),
        .psum_ready_i   (psum_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .cfg_err_o      (cfg_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_row(input int len, input int nout);
        cfg_len_i     = LEN_W'(len);
        cfg_num_out_i = OUT_W'(nout);
        cfg_start_i   = 1'b1;
        step();
        cfg_start_i   = 1'b0;
    endtask

    task automatic send_filter(input int d);
        int n = 0;
        filter_i       = DATA_W'(d);
        filter_valid_i = 1'b1;
        while (!filter_ready_o && n < 50) begin
            step();
            n++;
        end
        compared++;
        if (n >= 50) begin
            mismatched++;
            $display("[TB] FAIL filter_wait: filter_ready_o=%0b required=1 within 50 cycles", filter_ready_o);
        end
        step();
        filter_valid_i = 1'b0;
    endtask

    task automatic send_ifmap(input int d);
        int n = 0;
        ifmap_i       = DATA_W'(d);
        ifmap_valid_i = 1'b1;
        while (!ifmap_ready_o && n < 50) begin
            step();
            n++;
        end
        compared++;
        if (n >= 50) begin
            mismatched++;
            $display("[TB] FAIL ifmap_wait: ifmap_ready_o=%0b required=1 within 50 cycles", ifmap_ready_o);
        end
        step();
        ifmap_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!psum_valid_o && cycles < 100) begin
            step();
            cycles++;
        end
        compared++;
        if (!psum_valid_o) begin
            mismatched++;
            $display("[TB] FAIL psum_valid_wait: psum_valid_o=%0b required=1 within 100 cycles", psum_valid_o);
        end
    endtask

    // len=3, num_out=2, filter [1,2,3], ifmap [1,1,1,2] -> 6 then 9, with optional psum_ready_i stall.
    task automatic run_basic(input int stall);
        int lat;
        psum_ready_i = 1'b1;
        psum_i       = '0;
        psum_valid_i = 1'b1;
        start_row(3, 2);
        send_filter(1);
        send_filter(2);
        send_filter(3);
        send_ifmap(1);
        send_ifmap(1);
        send_ifmap(1);
        wait_valid(lat);
        compared++;
        if (lat !== 4) begin
            mismatched++;
            $display("[TB] FAIL basic_latency: got %0d cycles, required 4", lat);
        end
        compared++;
        if (psum_o !== PSUM_W'(6)) begin
            mismatched++;
            $display("[TB] FAIL basic_out0: psum_o=%0d required 6", $signed(psum_o));
        end
        if (stall > 0) begin
            psum_ready_i = 1'b0;
            for (int i = 0; i < stall; i++) begin
                step();
                compared++;
                if (psum_o !== PSUM_W'(6) || psum_valid_o !== 1'b1 || ifmap_ready_o !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL stall_hold: psum_o=%0d valid=%0b ifmap_ready=%0b required 6/1/0",
                             $signed(psum_o), psum_valid_o, ifmap_ready_o);
                end
            end
            psum_ready_i = 1'b1;
        end
        step();
        compared++;
        if (psum_valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL basic_after_out0: valid=%0b done=%0b busy=%0b required 0/0/1",
                     psum_valid_o, done_o, busy_o);
        end
        send_ifmap(2);
        wait_valid(lat);
        compared++;
        if (lat !== 4 || psum_o !== PSUM_W'(9)) begin
            mismatched++;
            $display("[TB] FAIL basic_out1: psum_o=%0d latency=%0d required 9/4", $signed(psum_o), lat);
        end
        step();
        compared++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || psum_valid_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_done: done=%0b busy=%0b valid=%0b required 1/0/0",
                     done_o, busy_o, psum_valid_o);
        end
        step();
        compared++;
        if (done_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_done_pulse: done=%0b required 0", done_o);
        end
        psum_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        step();
        compared++;
        if (psum_o !== '0 || psum_valid_o !== 1'b0 || filter_ready_o !== 1'b0 || ifmap_ready_o !== 1'b0 ||
            psum_ready_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || cfg_err_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: psum_o=%0d pv=%0b fr=%0b ir=%0b pr=%0b busy=%0b done=%0b err=%0b required all 0",
                     psum_o, psum_valid_o, filter_ready_o, ifmap_ready_o, psum_ready_o, busy_o, done_o, cfg_err_o);
        end
        rst = 1'b0;
        step();
        compared++;
        if (busy_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_idle: busy=%0b required 0", busy_o);
        end
    endtask

    task automatic test_basic();
        run_basic(0);
    endtask

    task automatic test_backpressure();
        run_basic(4);
    endtask

    // len=2, filter [-4,5], ifmap [3,2] -> -2; psum_i=-7 arrives late -> -9.
    task automatic test_psum_stall();
        psum_valid_i = 1'b0;
        psum_ready_i = 1'b1;
        start_row(2, 1);
        send_filter(-4);
        send_filter(5);
        send_ifmap(3);
        send_ifmap(2);
        for (int i = 0; i < 5; i++) begin
            step();
            compared++;
            if (psum_valid_o !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL stall_no_valid: cycle %0d psum_valid_o=%0b required 0", i, psum_valid_o);
            end
        end
        compared++;
        if (psum_ready_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL stall_psum_ready: psum_ready_o=%0b required 1", psum_ready_o);
        end
        psum_i       = PSUM_W'(-7);
        psum_valid_i = 1'b1;
        step();
        psum_valid_i = 1'b0;
        compared++;
        if (psum_valid_o !== 1'b1 || psum_o !== PSUM_W'(-9)) begin
            mismatched++;
            $display("[TB] FAIL stall_sum: psum_o=%0d valid=%0b required -9/1", $signed(psum_o), psum_valid_o);
        end
        step();
        compared++;
        if (done_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL stall_done: done=%0b required 1", done_o);
        end
    endtask

    task automatic test_overflow();
        int lat;
        int exp_pos;
        int exp_neg;
`ifdef PE_PSUM_SAT_EN
        exp_pos = 511;
        exp_neg = -512;
`else
        exp_pos = 259;
        exp_neg = 384;
`endif
        psum_i       = '0;
        psum_valid_i = 1'b1;
        psum_ready_i = 1'b1;
        start_row(3, 1);
        for (int i = 0; i < 3; i++) send_filter(127);
        for (int i = 0; i < 3; i++) send_ifmap(127);
        wait_valid(lat);
        compared++;
        if (psum_o !== PSUM_W'(exp_pos)) begin
            mismatched++;
            $display("[TB] FAIL overflow_pos: psum_o=%0d required %0d", $signed(psum_o), exp_pos);
        end
        step();
        step();
        start_row(3, 1);
        for (int i = 0; i < 3; i++) send_filter(-128);
        for (int i = 0; i < 3; i++) send_ifmap(127);
        wait_valid(lat);
        compared++;
        if (psum_o !== PSUM_W'(exp_neg)) begin
            mismatched++;
            $display("[TB] FAIL overflow_neg: psum_o=%0d required %0d", $signed(psum_o), exp_neg);
        end
        step();
        step();
        psum_valid_i = 1'b0;
    endtask

    // Rejected starts, then an ignored mid-row start on a len=1 row: filter 3, ifmap [-2,4], psum_i 1 -> -5, 13.
    task automatic test_cfg_errors();
        int lens[4]  = '{0, 4, 2, 2};
        int nouts[4] = '{5, 5, 0, 17};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_row(lens[i], nouts[i]);
            compared++;
            if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL cfg_err_%0d: err=%0b busy=%0b required 1/0", i, cfg_err_o, busy_o);
            end
            step();
            compared++;
            if (cfg_err_o !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL cfg_err_pulse_%0d: err=%0b required 0", i, cfg_err_o);
            end
        end
        start_row(1, 2);
        compared++;
        if (cfg_err_o !== 1'b0 || busy_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL cfg_good_start: err=%0b busy=%0b required 0/1", cfg_err_o, busy_o);
        end
        start_row(0, 0);
        compared++;
        if (cfg_err_o !== 1'b0 || busy_o !== 1'b1 || filter_ready_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL cfg_busy_start: err=%0b busy=%0b filter_ready=%0b required 0/1/1",
                     cfg_err_o, busy_o, filter_ready_o);
        end
        psum_i       = PSUM_W'(1);
        psum_valid_i = 1'b1;
        psum_ready_i = 1'b1;
        send_filter(3);
        send_ifmap(-2);
        wait_valid(lat);
        compared++;
        if (lat !== 2 || psum_o !== PSUM_W'(-5)) begin
            mismatched++;
            $display("[TB] FAIL len1_out0: psum_o=%0d latency=%0d required -5/2", $signed(psum_o), lat);
        end
        step();
        send_ifmap(4);
        wait_valid(lat);
        compared++;
        if (psum_o !== PSUM_W'(13)) begin
            mismatched++;
            $display("[TB] FAIL len1_out1: psum_o=%0d required 13", $signed(psum_o));
        end
        step();
        compared++;
        if (done_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL len1_done: done=%0b required 1", done_o);
        end
        psum_valid_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_mac();
        psum_valid_i = 1'b0;
        start_row(3, 2);
        send_filter(1);
        send_filter(2);
        send_filter(3);
        send_ifmap(1);
        send_ifmap(1);
        send_ifmap(1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        compared++;
        if (psum_o !== '0 || psum_valid_o !== 1'b0 || filter_ready_o !== 1'b0 || ifmap_ready_o !== 1'b0 ||
            psum_ready_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || cfg_err_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: psum_o=%0d pv=%0b fr=%0b ir=%0b pr=%0b busy=%0b done=%0b err=%0b required all 0",
                     psum_o, psum_valid_o, filter_ready_o, ifmap_ready_o, psum_ready_o, busy_o, done_o, cfg_err_o);
        end
        step();
        run_basic(0);
    endtask

    initial begin
        rst            = 1'b1;
        cfg_start_i    = 1'b0;
        cfg_len_i      = '0;
        cfg_num_out_i  = '0;
        filter_i       = '0;
        filter_valid_i = 1'b0;
        ifmap_i        = '0;
        ifmap_valid_i  = 1'b0;
        psum_i         = '0;
        psum_valid_i   = 1'b0;
        psum_ready_i   = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_psum_stall();
        test_overflow();
        test_cfg_errors();
        test_reset_mid_mac();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pe_row_mac.md
Name: pe_row_mac

Overview:
Parametrised row-stationary processing element, the next generation of the PE used in the systolic array.
- Holds one filter row (length configurable up to MAX_FILT_W) in a local scratchpad.
- Slides a stride-1 window over a streamed ifmap row and computes one dot product per output position.
- Adds each dot product to the incoming partial sum from the neighbouring PE and emits the result.
- Every data stream uses a valid/ready handshake; the block sits between the memory/feeder and the PE column psum chain.

Parameters:
DATA_W, 8, signed width of filter and ifmap words
PSUM_W, 10, signed width of psum_i/psum_o
MAX_FILT_W, 3, scratchpad depth (largest filter row width)
MAX_OUT, 16, largest output positions per row
LEN_W, $clog2(MAX_FILT_W+1), width of cfg_len_i
OUT_W, $clog2(MAX_OUT+1), width of cfg_num_out_i

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
cfg_start_i  in  1  start pulse; sampled only in IDLE
cfg_len_i  in  LEN_W  active filter row width, 1..MAX_FILT_W
cfg_num_out_i  in  OUT_W  output positions this row, 1..MAX_OUT
filter_i  in  DATA_W  signed filter word
filter_valid_i / filter_ready_o  in/out  1  filter handshake
ifmap_i  in  DATA_W  signed ifmap word
ifmap_valid_i / ifmap_ready_o  in/out  1  ifmap handshake
psum_i  in  PSUM_W  signed incoming partial sum
psum_valid_i / psum_ready_o  in/out  1  psum-in handshake
psum_o  out  PSUM_W  signed outgoing partial sum (registered)
psum_valid_o / psum_ready_i  out/in  1  psum-out handshake
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle pulse when the row completes
cfg_err_o  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset: state=IDLE; all ready/valid outputs, psum_o, busy_o, done_o, cfg_err_o = 0; counters and accumulator cleared. Scratchpad contents are don't-care. Reset mid-operation aborts the row immediately; no partial output is produced.
- A transfer occurs on an edge where valid and ready are both high. Ready outputs are functions of state only; they never depend on input valids.
- IDLE: on cfg_start_i:
  - If len is 0 or >MAX_FILT_W, or num_out is 0 or >MAX_OUT: pulse cfg_err_o and stay in IDLE.
  - Otherwise latch len and num_out, then go to LOAD_F.
- LOAD_F: filter_ready_o=1. Filter words are stored at f[0..len-1] in arrival order. After len words, go to FILL.
- FILL: ifmap_ready_o=1. Words shift into the window at x[len-1]; x[i] takes x[i+1] for i<len-1, so x[0] is the oldest. After len words, clear acc and go to MAC.
- MAC: one multiply per cycle for k=0..len-1: acc += f[k]*x[k]. Lasts exactly len cycles, then go to PSUM.
  - acc width is 2*DATA_W+$clog2(MAX_FILT_W); it cannot overflow internally.
- PSUM: psum_ready_o=1. On transfer, psum_o <= fit(acc + sext(psum_i)), psum_valid_o <= 1, go to OUT. PSUM waits indefinitely for psum_valid_i.
- OUT: psum_o and psum_valid_o are held stable until psum_ready_i. On transfer, psum_valid_o <= 0 and outputs_done is incremented.
  - If outputs_done == num_out: pulse done_o and go to IDLE.
  - Otherwise go to SHIFT.
- SHIFT: ifmap_ready_o=1. Accept one word (shifted into the window as in FILL), clear acc, go to MAC. The filter scratchpad is reused and is not reloaded.
- Latency: with psum_valid_i held high, psum_valid_o rises len+1 cycles after the edge accepting the last window ifmap word.
- Total ifmap words consumed per row = len + num_out - 1.
- len=1 boundary: MAC lasts 1 cycle, and the window is a single register.
- cfg_start_i while busy_o=1 is ignored, with no error pulse.
- fit(): defined under Optional Feature.

Optional Feature:
Macro PE_PSUM_SAT_EN.
- Defined: fit() saturates to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
- Undefined: fit() truncates to the low PSUM_W bits (two's-complement wrap).

Test Plan:
- Basic dot products: len=3, num_out=2, filter [1,2,3], ifmap [1,1,1,2], psum_i=0 both times -> psum_o 6 then 9; done_o pulses once after the second output transfer.
- Psum add and stall: len=2, filter [-4,5], ifmap [3,2], num_out=1, psum_valid_i raised 5 cycles late with psum_i=-7 -> psum_o=-9. psum_valid_o stays 0 until the cycle after the psum transfer.
- Overflow: len=3, filter [127,127,127], ifmap [127,127,127], psum_i=0 -> psum_o=511 with PE_PSUM_SAT_EN, 259 without; filter [-128]x3, ifmap [127]x3 -> -512 with saturation.
- Backpressure: hold psum_ready_i=0 for 4 cycles in the basic test -> psum_o stays at 6 with psum_valid_o=1, ifmap_ready_o=0 throughout, then the test continues normally.
- Config errors: start with len=0, then len=4, then num_out=0 -> cfg_err_o pulses each time, busy_o stays 0; a start asserted mid-row is ignored.
- Reset mid-MAC: assert rst in the second MAC cycle -> next cycle all outputs are 0 and state is IDLE; a fresh basic-test run then yields 6, 9.
